// File: rtl/line_pixel_writer.sv
// Command sequencer and framebuffer writer for the line stepper: loads a line, clips each pixel, writes in-bounds ones.
// Latency: 1 LOAD + (SETTLE_CYC+1) settle + >=1 write cycle per pixel, +1 STEP between pixels, +1 DONE at the end.
// Backpressure: cmd_ready only in IDLE; mem_req is held with stable addr/data until mem_ack.
module line_pixel_writer #(
    parameter int FB_W       = 640,
    parameter int FB_H       = 480,
    parameter int ADDR_W     = 32,
    parameter int COLOR_W    = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [15:0]        cmd_x1,
    input  logic [15:0]        cmd_y1,
    input  logic [15:0]        cmd_x2,
    input  logic [15:0]        cmd_y2,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic [ADDR_W-1:0]  fb_base,
    output logic               calc_o,
    output logic [15:0]        line_x1,
    output logic [15:0]        line_y1,
    output logic [15:0]        line_x2,
    output logic [15:0]        line_y2,
    output logic               step_o,
    input  logic [15:0]        px_x,
    input  logic [15:0]        px_y,
    input  logic               line_done,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               cmd_done,
    output logic [15:0]        pix_written,
    output logic [15:0]        pix_clipped
);

    localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SETTLE_CYC);
    localparam logic [16:0]       FB_W_L      = 17'(FB_W);
    localparam logic [16:0]       FB_H_L      = 17'(FB_H);
    localparam logic [ADDR_W-1:0] FB_W_A      = ADDR_W'(FB_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_WRITE,
        S_STEP,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   settle_cnt;
    logic               last;
    logic               clip;
    logic [ADDR_W-1:0]  base;
    logic               px_clip;
    logic [ADDR_W-1:0]  px_addr;

    assign px_clip = ({1'b0, px_x} >= FB_W_L) || ({1'b0, px_y} >= FB_H_L);
    assign px_addr = base + ADDR_W'(px_y) * FB_W_A + ADDR_W'(px_x);

    // Handshake outputs decode straight from state so reset drops them immediately.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign calc_o    = (state == S_LOAD);
    assign step_o    = (state == S_STEP);
    assign cmd_done  = (state == S_DONE);
    assign mem_req   = (state == S_WRITE) && !clip;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cmd_valid) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == '0) state_nxt = S_WRITE;
            S_WRITE:  if (clip || mem_ack) state_nxt = last ? S_DONE : S_STEP;
            S_STEP:   state_nxt = S_SETTLE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            last        <= 1'b0;
            clip        <= 1'b0;
            base        <= '0;
            line_x1     <= '0;
            line_y1     <= '0;
            line_x2     <= '0;
            line_y2     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            pix_written <= '0;
            pix_clipped <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        line_x1     <= cmd_x1;
                        line_y1     <= cmd_y1;
                        line_x2     <= cmd_x2;
                        line_y2     <= cmd_y2;
                        mem_wdata   <= cmd_color;
                        base        <= fb_base;
                        pix_written <= '0;
                        pix_clipped <= '0;
                    end
                end
                S_LOAD, S_STEP: settle_cnt <= SETTLE_INIT;
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        last     <= line_done;
                        clip     <= px_clip;
                        mem_addr <= px_addr;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (clip) begin
                        if (pix_clipped != 16'hFFFF) pix_clipped <= pix_clipped + 16'd1;
                    end else if (mem_ack) begin
                        if (pix_written != 16'hFFFF) pix_written <= pix_written + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
